// File: rtl/alu_op_sequencer.sv
// Sequences register-file operations through an external combinational ALU.
// Requests are accepted one at a time; every request yields exactly one response.
module alu_op_sequencer #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [1:0] req_dst,
  input  logic [1:0] req_srca,
  input  logic [1:0] req_srcb,
  input  logic [7:0] req_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_mode,
  input  logic [7:0] alu_s,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] op_count,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; once raised, valid and its payload hold until that transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    LOAD = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0001;
  localparam logic [3:0] OP_CLEAR = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1111;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [1:0] dst_q, dst_d;
  logic [1:0] srca_q, srca_d;
  logic [1:0] srcb_q, srcb_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] op_count_q, op_count_d;
  logic       is_alu_op;

  always_comb begin
    is_alu_op = 1'b0;
    case (req_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_CLEAR: is_alu_op = 1'b1;
      default:                                         is_alu_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    imm_d       = imm_q;
    regs_d      = regs_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          dst_d  = req_dst;
          srca_d = req_srca;
          srcb_d = req_srcb;
          imm_d  = req_imm;
          if (is_alu_op) begin
            state_d = OPER;
          end else if (req_op == OP_LOAD) begin
            state_d = LOAD;
          end else begin
            // Illegal opcode answers straight away and leaves the registers alone.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_err_d   = 1'b1;
          end
        end
      end
      OPER: begin
        regs_d[dst_q] = alu_s;
        rsp_data_d    = alu_s;
        rsp_err_d     = 1'b0;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      LOAD: begin
        regs_d[dst_q] = imm_q;
        rsp_data_d    = imm_q;
        rsp_err_d     = 1'b0;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 4'h0;
      dst_q       <= 2'd0;
      srca_q      <= 2'd0;
      srcb_q      <= 2'd0;
      imm_q       <= 8'h00;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      op_count_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      imm_q       <= imm_d;
      regs_q      <= regs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  // Operands are driven from the registers as they stand before the OPER write,
  // so a source that equals the destination reads its old value.
  assign alu_a     = (state_q == OPER) ? regs_q[srca_q] : 8'h00;
  assign alu_b     = (state_q == OPER) ? regs_q[srcb_q] : 8'h00;
  assign alu_mode  = (state_q == OPER) ? op_q : OP_CLEAR;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;
  assign dbg_state = state_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: NREG, 4, number of 8-bit operand registers; fixed at 4 (2-bit register addresses).
REQ-002 Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  sequencer can accept a request this cycle.
REQ-007 req_op  input  4  operation: 0011 add, 0100 sub, 0101 and, 0110 or, 0001 not, 1010 clear, 1111 load immediate.
REQ-008 req_dst, req_srca, req_srcb  input  2 each  destination and source register indices.
REQ-009 req_imm  input  8  immediate value for load.
REQ-010 alu_a, alu_b  output  8 each  operands to the external ALU.
REQ-011 alu_mode  output  4  mode to the external ALU.
REQ-012 alu_s  input  8  combinational ALU result.
REQ-013 rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts.
REQ-014 rsp_data  output  8  value written to the destination register.
REQ-015 rsp_err  output  1  request carried an illegal opcode.
REQ-016 op_count  output  8  number of completed responses.

Function
REQ-017 FSM states SHALL be IDLE, OPER, LOAD, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on req_valid=1, latch op, dst, srca, srcb, imm; go to OPER for 0011/0100/0101/0110/0001/1010, LOAD for 1111, RESP with rsp_err=1 for any other opcode.
REQ-019 OPER (one cycle): alu_a=reg[srca], alu_b=reg[srcb], alu_mode=latched op; at the cycle's end, write alu_s to reg[dst] and rsp_data, clear rsp_err, go to RESP.
REQ-020 LOAD (one cycle): write imm to reg[dst] and rsp_data, clear rsp_err, go to RESP; ALU outputs ignored.
REQ-021 Illegal opcode: no register write; rsp_data=0x00; rsp_err=1.
REQ-022 Outside OPER: alu_a=0x00, alu_b=0x00, alu_mode=1010, so the ALU output is defined.
REQ-023 RESP: rsp_valid=1; rsp_data and rsp_err stable until rsp_ready=1; on acceptance go to IDLE, increment op_count (mod 256, 0xFF wraps to 0x00).
REQ-024 Latency: request accepted at edge k; rsp_valid=1 from cycle after edge k+1 (ALU/LOAD) or after edge k (illegal).
REQ-025 No back-to-back acceptance: req_ready=0 during the RESP acceptance cycle; next request no earlier than the following IDLE cycle.
REQ-026 Source equals destination is legal: operands are read before the write at the end of OPER.
REQ-027 Arithmetic is modulo 256 (ALU behaviour); no overflow/carry is reported.

Reset
REQ-028 On rst=1 at an edge: state IDLE; all registers 0x00; rsp_valid=0, rsp_data=0x00, rsp_err=0, op_count=0x00; req_ready=1 in the following cycle.
REQ-029 Reset SHALL take priority over any handshake in the same cycle; an in-flight operation is discarded without a register write or count increment.

Verification
REQ-030 Load 0x05->r0, load 0x03->r1, add r2=r0+r1 -> rsp_data 0x08, alu_mode 0011 seen for exactly one cycle, op_count 3.
REQ-031 Sub r3=r1-r0 (0x03-0x05) -> rsp_data 0xFE; not r0 (0x05) -> 0xFA; and/or of 0xF0, 0x3C -> 0x30 / 0xFC.
REQ-032 Opcode 0111 -> rsp_err=1, rsp_data 0x00, registers unchanged; following legal op -> rsp_err=0.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, second request not accepted.
REQ-034 rst asserted during OPER -> next cycle rsp_valid=0, registers 0x00, op_count 0x00, no response issued.
REQ-035 256 completed ops -> op_count wraps to 0x00; add r0=r0+r0 with r0=0x80 -> 0x00.
